// File: rtl/splat_tile_compositor.sv
// splat_tile_compositor
//
// Front-to-back alpha compositor for one screen tile of the Gaussian splatting
// pipeline. LANES pixels are blended in parallel, one Gaussian per cycle. After
// the Gaussian tagged end_of_tile, the tile is streamed out one lane per beat,
// and then every lane is cleared for the next tile.
//
// Optional feature: define SPLAT_EARLY_TERM_EN to enable early termination.
// With it, a lane whose transmittance is below T_MIN is frozen. tile_done then
// reports when every lane is frozen. Without it, tile_done is tied low.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   in_valid     Gaussian beat valid
//   in_ready     high while accumulating
//   end_of_tile  accepted beat is the tile's last Gaussian
//   alpha        per-lane alpha, Q0.ALPHA_W, lane i at [i*ALPHA_W +: ALPHA_W]
//   color        Gaussian colour, CHANNELS x CH_W, broadcast to all lanes
//   out_valid    drain beat valid
//   out_ready    drain beat consumed
//   out_lane     lane index of the drain beat
//   out_pixel    composited colour of out_lane
//   out_trans    residual transmittance of out_lane, Q1.ALPHA_W
//   out_last     drain beat carries lane LANES-1
//   tile_done    every lane terminated early
module splat_tile_compositor #(
  parameter int LANES    = 16,
  parameter int CHANNELS = 3,
  parameter int CH_W     = 8,
  parameter int ALPHA_W  = 8,
  parameter int T_MIN    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         end_of_tile,
  input  logic [LANES*ALPHA_W-1:0]     alpha,
  input  logic [CHANNELS*CH_W-1:0]     color,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(LANES)-1:0]     out_lane,
  output logic [CHANNELS*CH_W-1:0]     out_pixel,
  output logic [ALPHA_W:0]             out_trans,
  output logic                         out_last,
  output logic                         tile_done
);

  localparam int LW = $clog2(LANES);
  localparam int TW = ALPHA_W + 1;
  localparam logic [TW-1:0] T_ONE = {1'b1, {ALPHA_W{1'b0}}};
`ifdef SPLAT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_cnt_q;
  logic [TW-1:0]   t_q      [LANES];
  logic [CH_W-1:0] acc_q    [LANES][CHANNELS];
  logic [TW-1:0]   contrib  [LANES];
  logic [TW-1:0]   t_d      [LANES];
  logic [CH_W-1:0] acc_d    [LANES][CHANNELS];
  logic [LANES-1:0] lane_en;
  logic            beat, drain_hs, last_hs;

  // (alpha * T) >> ALPHA_W. The result never exceeds T, so it fits in TW bits.
  function automatic logic [TW-1:0] mul_alpha(input logic [ALPHA_W-1:0] a,
                                              input logic [TW-1:0] t);
    logic [ALPHA_W+TW-1:0] p;
    p = {{TW{1'b0}}, a} * {{ALPHA_W{1'b0}}, t};
    return TW'(p >> ALPHA_W);
  endfunction

  // (contrib * colour) >> ALPHA_W. contrib <= 1.0, so the result is <= colour.
  function automatic logic [CH_W-1:0] scale_color(input logic [TW-1:0] c,
                                                  input logic [CH_W-1:0] col);
    logic [TW+CH_W-1:0] p;
    p = {{CH_W{1'b0}}, c} * {{TW{1'b0}}, col};
    return CH_W'(p >> ALPHA_W);
  endfunction

  assign beat     = in_valid && in_ready;
  assign drain_hs = out_valid && out_ready;
  assign last_hs  = drain_hs && out_last;

  // Per-lane blend of the current Gaussian. Frozen lanes pass their state through.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_en[i] = !EARLY_TERM || (int'(t_q[i]) >= T_MIN);
      contrib[i] = mul_alpha(alpha[i*ALPHA_W +: ALPHA_W], t_q[i]);
      t_d[i]     = lane_en[i] ? t_q[i] - contrib[i] : t_q[i];
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_d[i][ch] = lane_en[i]
                     ? acc_q[i][ch] + scale_color(contrib[i], color[ch*CH_W +: CH_W])
                     : acc_q[i][ch];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments, so every flop samples
    // pre-edge values regardless of process order.
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through this block leaves state_d
    // unassigned. This prevents a latch from being inferred.
    state_d = state_q;
    case (state_q)
      ACCUM:   if (beat && end_of_tile) state_d = DRAIN;
      DRAIN:   if (last_hs)             state_d = ACCUM;
      default:                          state_d = ACCUM;
    endcase
  end

  // Outputs. These are a decode of the state register plus a mux of the lane registers.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DRAIN);
    out_lane  = lane_cnt_q;
    out_last  = (state_q == DRAIN) && (lane_cnt_q == LW'(LANES - 1));
    out_trans = t_q[lane_cnt_q];
    for (int ch = 0; ch < CHANNELS; ch++) begin
      out_pixel[ch*CH_W +: CH_W] = acc_q[lane_cnt_q][ch];
    end
  end

  // Lane registers and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
      // NOTE: the lane registers are flops rather than a RAM. They are cleared
      // on both resets, because a tile that was aborted must leave no residue.
      for (int i = 0; i < LANES; i++) begin
        t_q[i] <= T_ONE;
        for (int ch = 0; ch < CHANNELS; ch++) acc_q[i][ch] <= '0;
      end
    end else if (last_hs) begin
      lane_cnt_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        t_q[i] <= T_ONE;
        for (int ch = 0; ch < CHANNELS; ch++) acc_q[i][ch] <= '0;
      end
    end else if (drain_hs) begin
      lane_cnt_q <= lane_cnt_q + 1'b1;
    end else if (beat) begin
      if (end_of_tile) lane_cnt_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        t_q[i] <= t_d[i];
        for (int ch = 0; ch < CHANNELS; ch++) acc_q[i][ch] <= acc_d[i][ch];
      end
    end
  end

`ifdef SPLAT_EARLY_TERM_EN
  // tile_done is registered. It is recomputed from the post-update
  // transmittances on every accepted beat, so it already reflects the beat
  // just taken. It is held through the drain.
  logic             done_q;
  logic [LANES-1:0] frozen_d;

  always_comb begin
    for (int i = 0; i < LANES; i++) frozen_d[i] = (int'(t_d[i]) < T_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       done_q <= 1'b0;
    else if (last_hs) done_q <= 1'b0;
    else if (beat)    done_q <= &frozen_d;
  end

  assign tile_done = done_q;
`else
  assign tile_done = 1'b0;
`endif

endmodule

// File: tb/tb_splat_tile_compositor.sv
// Self-checking bench for splat_tile_compositor (LANES=4, CHANNELS=3, 8-bit colour and alpha, T_MIN=32).
// The table vectors carry hand-derived expectations. The random tiles are
// checked against an integer model of the blending rules.
module tb_splat_tile_compositor;

  localparam int LANES = 4, CHANNELS = 3, CH_W = 8, ALPHA_W = 8, T_MIN = 32;
`ifdef SPLAT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, end_of_tile = 1'b0, out_ready = 1'b0;
  logic [31:0] alpha = '0;
  logic [23:0] color = '0;
  logic        in_ready, out_valid, out_last, tile_done;
  logic [1:0]  out_lane;
  logic [23:0] out_pixel;
  logic [8:0]  out_trans;

  always #5 clk = ~clk;

  splat_tile_compositor #(
    .LANES(LANES), .CHANNELS(CHANNELS), .CH_W(CH_W), .ALPHA_W(ALPHA_W), .T_MIN(T_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .end_of_tile(end_of_tile), .alpha(alpha), .color(color),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_pixel(out_pixel), .out_trans(out_trans), .out_last(out_last),
    .tile_done(tile_done)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model: plain integer arithmetic ----------------
  int m_t   [LANES];
  int m_acc [LANES][CHANNELS];

  function automatic void model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_t[i] = 256;
      for (int ch = 0; ch < CHANNELS; ch++) m_acc[i][ch] = 0;
    end
  endfunction

  function automatic void model_beat(input logic [31:0] a, input logic [23:0] c);
    int contrib;
    for (int i = 0; i < LANES; i++) begin
      if (!(ET && m_t[i] < T_MIN)) begin
        contrib = (int'(a[i*8 +: 8]) * m_t[i]) / 256;
        for (int ch = 0; ch < CHANNELS; ch++)
          m_acc[i][ch] += (contrib * int'(c[ch*8 +: 8])) / 256;
        m_t[i] -= contrib;
      end
    end
  endfunction

  function automatic bit model_done();
    if (!ET) return 1'b0;
    for (int i = 0; i < LANES; i++) if (m_t[i] >= T_MIN) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [23:0] rgb(input int r, input int g, input int b);
    return {8'(b), 8'(g), 8'(r)};
  endfunction

  function automatic logic [31:0] all4(input int x);
    return {4{8'(x)}};
  endfunction

  // Presents one beat for one cycle while the DUT is in ACCUM.
  task automatic drive_beat(input logic [31:0] a, input logic [23:0] c, input bit eot);
    alpha = a; color = c; end_of_tile = eot; in_valid = 1'b1;
    check("beat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; end_of_tile = 1'b0;
    model_beat(a, c);
    // A beat with end_of_tile must give out_valid one cycle after acceptance, with lane 0 presented.
    check("beat_out_valid", out_valid, eot);
    if (eot) check("beat_first_lane", out_lane, 0);
  endtask

  task automatic check_lane(input string tag, input int lane);
    logic [23:0] exp_pix;
    for (int ch = 0; ch < CHANNELS; ch++) exp_pix[ch*8 +: 8] = 8'(m_acc[lane][ch]);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_lane"},  out_lane, lane);
    check({tag, "_pixel"}, out_pixel, exp_pix);
    check({tag, "_trans"}, out_trans, m_t[lane]);
    check({tag, "_last"},  out_last, lane == LANES - 1);
    check({tag, "_done"},  tile_done, model_done());
  endtask

  // Drains one tile against the model, with optional random out_ready stalls.
  task automatic drain_model(input string tag, input bit stall);
    int  lane = 0;
    int  cycles = 0;
    bit  rdy;
    while (lane < LANES && cycles < 100) begin
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = rdy;
      check_lane($sformatf("%s_l%0d", tag, lane), lane);
      @(posedge clk); #1;
      if (rdy) lane++;
      cycles++;
    end
    out_ready = 1'b0;
    if (lane < LANES) check({tag, "_drain_timeout"}, 0, 1);
    check({tag, "_in_ready_after"},  in_ready, 1);
    check({tag, "_out_valid_after"}, out_valid, 0);
    model_reset();
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct packed {
    logic [LANES-1:0][7:0]               a;
    logic [23:0]                         c;
    logic                                eot;
    logic [LANES-1:0][23:0]              exp_pix;
    logic [LANES-1:0][8:0]               exp_t;
    logic                                exp_done;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic drain_table(input vec_t v, input int idx);
    out_ready = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("vec%0d_l%0d_valid", idx, l), out_valid, 1);
      check($sformatf("vec%0d_l%0d_lane",  idx, l), out_lane, l);
      check($sformatf("vec%0d_l%0d_pixel", idx, l), out_pixel, v.exp_pix[l]);
      check($sformatf("vec%0d_l%0d_trans", idx, l), out_trans, v.exp_t[l]);
      check($sformatf("vec%0d_l%0d_last",  idx, l), out_last, l == LANES - 1);
      check($sformatf("vec%0d_l%0d_done",  idx, l), tile_done, v.exp_done);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check($sformatf("vec%0d_in_ready_after", idx), in_ready, 1);
    check($sformatf("vec%0d_out_valid_after", idx), out_valid, 0);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [23:0] c;
    int nb;

    // Alpha 0 on every lane: the tile must drain untouched.
    vecs[0] = '{a: all4(0), c: rgb(10, 20, 30), eot: 1'b1,
                exp_pix: {4{rgb(0, 0, 0)}}, exp_t: {4{9'd256}}, exp_done: 1'b0};
    // Single Gaussian: alpha 0.5, colour (255,128,0) gives (127,64,0) and T=128.
    vecs[1] = '{a: all4(128), c: rgb(255, 128, 0), eot: 1'b1,
                exp_pix: {4{rgb(127, 64, 0)}}, exp_t: {4{9'd128}}, exp_done: 1'b0};
    // Two Gaussians. ch0: 200*0.5 = 100, then 100*0.25 = 25, total 125.
    // ch2: 25 + 12 = 37. T: 256 -> 128 -> 64.
    vecs[2] = '{a: all4(128), c: rgb(200, 0, 50), eot: 1'b0,
                exp_pix: '0, exp_t: '0, exp_done: 1'b0};
    vecs[3] = '{a: all4(128), c: rgb(100, 0, 50), eot: 1'b1,
                exp_pix: {4{rgb(125, 0, 37)}}, exp_t: {4{9'd64}}, exp_done: 1'b0};
    // Early termination. With the feature, T=16 freezes each lane.
    // Without it, the second beat goes through.
    vecs[4] = '{a: all4(240), c: rgb(255, 255, 255), eot: 1'b0,
                exp_pix: '0, exp_t: '0, exp_done: 1'b0};
    vecs[5] = '{a: all4(240), c: rgb(255, 255, 255), eot: 1'b1,
                exp_pix: ET ? {4{rgb(239, 239, 239)}} : {4{rgb(253, 253, 253)}},
                exp_t:   ET ? {4{9'd16}} : {4{9'd1}}, exp_done: ET};
    // Distinct per-lane alphas 0, 64, 255 and 128 (lane 0 first).
    vecs[6] = '{a: {8'd128, 8'd255, 8'd64, 8'd0}, c: rgb(255, 100, 7), eot: 1'b1,
                exp_pix: {rgb(127, 50, 3), rgb(254, 99, 6), rgb(63, 25, 1), rgb(0, 0, 0)},
                exp_t: {9'd128, 9'd1, 9'd192, 9'd256}, exp_done: 1'b0};

    model_reset();

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_tile_done", tile_done, 0);
    check("rst_out_last",  out_last, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready",  in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Table vectors
    for (int v = 0; v < NV; v++) begin
      drive_beat(vecs[v].a, vecs[v].c, vecs[v].eot);
      if (!vecs[v].eot) check($sformatf("vec%0d_in_ready_mid", v), in_ready, 1);
      if (vecs[v].eot) drain_table(vecs[v], v);
    end

    // Backpressure. Lane 1 is held for 3 cycles while upstream keeps in_valid high.
    drive_beat({8'd10, 8'd90, 8'd170, 8'd250}, rgb(30, 140, 220), 1'b1);
    out_ready = 1'b1;
    check_lane("bp_l0", 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; end_of_tile = 1'b1; alpha = all4(99); color = rgb(1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      check_lane($sformatf("bp_hold%0d", k), 1);
      check($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int l = 1; l < LANES; l++) begin
      check_lane($sformatf("bp_l%0d", l), l);
      check($sformatf("bp_l%0d_in_ready", l), in_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);
    in_valid = 1'b0; end_of_tile = 1'b0; out_ready = 1'b0;
    model_reset();

    // Reset asserted mid-drain while lane 2 is presented
    drive_beat(all4(200), rgb(50, 60, 70), 1'b1);
    out_ready = 1'b1;
    for (int l = 0; l < 2; l++) begin
      check_lane($sformatf("rmd_l%0d", l), l);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("rmd_lane2_presented", out_lane, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rmd_out_valid", out_valid, 0);
    check("rmd_out_last",  out_last, 0);
    check("rmd_tile_done", tile_done, 0);
    check("rmd_in_ready",  in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    drive_beat(all4(0), rgb(9, 9, 9), 1'b1);
    drain_model("rmd_clean", 1'b0);

    // Random tiles against the model
    for (int t = 0; t < 25; t++) begin
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < LANES; i++)
          a[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        c = 24'($urandom);
        drive_beat(a, c, b == nb - 1);
      end
      drain_model($sformatf("rnd%0d", t), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
